// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types and helpers for the RISC-V immediate generator.
//   imm_fmt_e      : 3-bit instruction format code (R,I,S,B,U,J,Z,X)
//   OP_*           : major opcode encodings (instr[6:0])
//   imm_fmt_decode : opcode/funct3 -> format code
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6,
    FMT_X = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  // SYSTEM splits on funct3[2]: immediate-operand CSR ops carry a 5-bit zimm.
  function automatic imm_fmt_e imm_fmt_decode(input logic [6:0] opcode,
                                               input logic [2:0] funct3);
    imm_fmt_e fmt;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: fmt = FMT_I;
      OP_STORE:                           fmt = FMT_S;
      OP_BRANCH:                          fmt = FMT_B;
      OP_LUI, OP_AUIPC:                   fmt = FMT_U;
      OP_JAL:                             fmt = FMT_J;
      OP_SYSTEM: fmt = ((funct3 & 3'b100) != 3'b000) ? FMT_Z : FMT_I;
      OP_REG, OP_REG32:                   fmt = FMT_R;
      default:                            fmt = FMT_X;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen_core.sv
// imm_gen_core: combinational immediate extraction.
// Optional feature macro: IMM_ILLEGAL_EN (adds illegal_o).
//   instr_i   [31:0]     raw 32-bit instruction
//   imm_o     [XLEN-1:0] reassembled, sign/zero-extended immediate
//   fmt_o     [2:0]      format code
//   illegal_o            unknown format or non-32-bit encoding (IMM_ILLEGAL_EN only)
module imm_gen_core
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o
`ifdef IMM_ILLEGAL_EN
  ,
  output logic            illegal_o
`endif
);

  always_comb begin
    fmt_o = imm_fmt_decode(instr_i[6:0], instr_i[14:12]);
    imm_o = '0;
    case (fmt_o)
      // CSR address in SYSTEM-I is an unsigned field, not an offset.
      FMT_I: imm_o = (instr_i[6:0] == OP_SYSTEM) ? XLEN'(instr_i[31:20])
                                                 : XLEN'($signed(instr_i[31:20]));
      FMT_S: imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      FMT_B: imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                    instr_i[11:8], 1'b0}));
      FMT_U: imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
      FMT_J: imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                    instr_i[30:21], 1'b0}));
      FMT_Z: imm_o = XLEN'(instr_i[19:15]);
      default: imm_o = '0;
    endcase
  end

`ifdef IMM_ILLEGAL_EN
  assign illegal_o = (fmt_o == FMT_X) || (instr_i[1:0] != 2'b11);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready handshake
// and a 2-entry skid buffer (main output register + one skid register).
// Optional feature macro: IMM_ILLEGAL_EN (adds out_illegal).
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_instr        upstream handshake + instruction
//   out_valid/out_ready               downstream handshake
//   out_imm [XLEN-1:0], out_fmt [2:0] extended immediate and format code
//   out_illegal                       illegal flag (IMM_ILLEGAL_EN only)
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt
`ifdef IMM_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  logic [XLEN-1:0] core_imm;
  imm_fmt_e        core_fmt;

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_imm_q,   main_imm_d;
  imm_fmt_e        main_fmt_q,   main_fmt_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  imm_fmt_e        skid_fmt_q,   skid_fmt_d;
`ifdef IMM_ILLEGAL_EN
  logic            core_ill;
  logic            main_ill_q, main_ill_d;
  logic            skid_ill_q, skid_ill_d;
`endif

  logic accept;

  imm_gen_core #(.XLEN(XLEN)) u_core (
    .instr_i   (in_instr),
    .imm_o     (core_imm),
    .fmt_o     (core_fmt)
`ifdef IMM_ILLEGAL_EN
    ,
    .illegal_o (core_ill)
`endif
  );

  // in_ready depends only on registered skid occupancy.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
`ifdef IMM_ILLEGAL_EN
    main_ill_d   = main_ill_q;
    skid_ill_d   = skid_ill_q;
`endif
    if (!main_valid_q || out_ready) begin
      // Main is free this edge; a full skid always has priority and
      // blocks new acceptance (in_ready=0) so ordering is kept.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        skid_valid_d = 1'b0;
`ifdef IMM_ILLEGAL_EN
        main_ill_d   = skid_ill_q;
`endif
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_imm_d   = core_imm;
        main_fmt_d   = core_fmt;
`ifdef IMM_ILLEGAL_EN
        main_ill_d   = core_ill;
`endif
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = core_imm;
      skid_fmt_d   = core_fmt;
`ifdef IMM_ILLEGAL_EN
      skid_ill_d   = core_ill;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FMT_R;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_R;
`ifdef IMM_ILLEGAL_EN
      main_ill_q   <= 1'b0;
      skid_ill_q   <= 1'b0;
`endif
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
`ifdef IMM_ILLEGAL_EN
      main_ill_q   <= main_ill_d;
      skid_ill_q   <= skid_ill_d;
`endif
    end
  end

  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_fmt   = main_fmt_q;
`ifdef IMM_ILLEGAL_EN
  assign out_illegal = main_ill_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=32): reset state, per-format
// immediates, skid-buffer backpressure, async reset with skid full, and a
// random valid/ready stream checked against a queue of table indices.
module tb_imm_gen_pipe;

  localparam int XLEN = 32;
  localparam int NT   = 13;

  // Hand-computed vectors: instruction, expected immediate, expected format.
  localparam logic [31:0] T_INSTR [NT] = '{
    32'hFFF00093,  // ADDI x1,x0,-1
    32'hFE512E23,  // SW
    32'h123450B7,  // LUI
    32'hFF9FF06F,  // JAL -8
    32'h000FD073,  // CSRRWI rs1=0x1F
    32'hFE000EE3,  // BEQ -4
    32'h00B50533,  // ADD
    32'h0000007F,  // unknown opcode
    32'hFFF01073,  // CSRRW csr=0xFFF (zero-extended)
    32'h7FF02083,  // LW +2047
    32'hFFFFF017,  // AUIPC
    32'hFFF00092,  // opcode low bits != 11
    32'h0080006F   // JAL +8
  };
  localparam logic [31:0] T_IMM [NT] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8, 32'h0000001F,
    32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000FFF, 32'h000007FF,
    32'hFFFFF000, 32'h00000000, 32'h00000008
  };
  localparam logic [2:0] T_FMT [NT] = '{
    3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd3, 3'd0, 3'd7, 3'd1, 3'd1, 3'd4, 3'd7, 3'd5
  };
`ifdef IMM_ILLEGAL_EN
  localparam logic T_ILL [NT] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0
  };
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
`ifdef IMM_ILLEGAL_EN
  logic            out_illegal;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  imm_gen_pipe #(.XLEN(XLEN), .ILEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt)
`ifdef IMM_ILLEGAL_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int idx);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_imm"},   64'(out_imm),   64'(T_IMM[idx]));
    chk({tag, "_fmt"},   64'(out_fmt),   64'(T_FMT[idx]));
`ifdef IMM_ILLEGAL_EN
    chk({tag, "_ill"},   64'(out_illegal), 64'(T_ILL[idx]));
`endif
  endtask

  int              exp_q[$];
  int              idx;
  int              e;
  bit              stalled;
  logic [XLEN-1:0] held_imm;
  logic [2:0]      held_fmt;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_imm",   64'(out_imm),   64'd0);
    chk("rst_fmt",   64'(out_fmt),   64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready",  64'(in_ready),  64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Back-to-back stream through every vector, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < NT; i++) begin
      in_valid = 1'b1;
      in_instr = T_INSTR[i];
      tick();
      chk_out($sformatf("stream%0d", i), i);
      chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: beats A,B accepted, C refused, output held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = T_INSTR[0];
    tick();
    chk_out("bp_a", 0);
    chk("bp_a_in_ready", 64'(in_ready), 64'd1);
    in_instr = T_INSTR[1];
    tick();
    chk_out("bp_a_hold", 0);
    chk("bp_b_in_ready", 64'(in_ready), 64'd0);
    in_instr = T_INSTR[2];
    tick();
    chk_out("bp_a_hold2", 0);
    chk("bp_c_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk_out("bp_b", 1);
    chk("bp_skid_empty_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp_c", 2);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset with skid full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = T_INSTR[3];
    tick();
    in_instr = T_INSTR[4];
    tick();
    in_valid = 1'b0;
    chk("mid_rst_skid_full", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_rel_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_rel_in_ready",  64'(in_ready),  64'd1);

    // Random valid/ready stream, scoreboarded by table index
    stalled  = 1'b0;
    held_imm = '0;
    held_fmt = '0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      idx       = int'($urandom_range(0, NT - 1));
      in_instr  = T_INSTR[idx];
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        chk("rnd_hold_valid", 64'(out_valid), 64'd1);
        chk("rnd_hold_imm",   64'(out_imm),   64'(held_imm));
        chk("rnd_hold_fmt",   64'(out_fmt),   64'(held_fmt));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_imm", 64'(out_imm), 64'(T_IMM[e]));
          chk("rnd_fmt", 64'(out_fmt), 64'(T_FMT[e]));
        end
      end
      stalled  = out_valid && !out_ready;
      held_imm = out_imm;
      held_fmt = out_fmt;
      if (in_valid && in_ready) exp_q.push_back(idx);
      tick();
    end

    // Bounded drain of whatever is still in flight
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("drain_imm", 64'(out_imm), 64'(T_IMM[e]));
        chk("drain_fmt", 64'(out_fmt), 64'(T_FMT[e]));
      end
      tick();
    end
    chk("drain_sb_empty",  64'(exp_q.size()), 64'd0);
    #1;
    chk("drain_out_valid", 64'(out_valid),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
